// File: rtl/line_window_ctrl.sv
// Sequencer for the 4-row line-buffer chain of a 5x5 window: streams pixels,
// appends 2*IMG_W+2 zero shifts, and reports the centre of each completed window.
module line_window_ctrl #(
  parameter int IMG_W = 17,
  parameter int IMG_H = 17,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          shift_en_o,
  output logic          flush_o,
  output logic          win_valid_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int LEAD = 2 * IMG_W + 2;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int SW   = $clog2(NPIX + LEAD + 1);
  localparam int FW   = $clog2(LEAD + 1);

  localparam logic [IW-1:0] IN_LAST  = IW'(NPIX - 1);
  localparam logic [SW-1:0] SH_LEAD  = SW'(LEAD);
  localparam logic [FW-1:0] FL_LAST  = FW'(LEAD - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_in_cnt;
  logic [SW-1:0] r_sh_cnt;
  logic [FW-1:0] r_fl_cnt;
  logic [RW-1:0] r_nrow;
  logic [CW-1:0] r_ncol;
  logic          w_last_px;
  logic          w_win_shift;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  assign w_last_px = (r_state == S_STREAM) && valid_i && (r_in_cnt == IN_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_next = S_STREAM;
      S_STREAM: if (w_last_px) w_state_next = S_FLUSH;
      S_FLUSH:  if (r_fl_cnt == FL_LAST) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o    = 1'b0;
    shift_en_o = 1'b0;
    flush_o    = 1'b0;
    case (r_state)
      S_STREAM: begin
        ready_o    = 1'b1;
        shift_en_o = valid_i;
      end
      S_FLUSH: begin
        shift_en_o = 1'b1;
        flush_o    = 1'b1;
      end
      default: ;
    endcase
  end

  // The first LEAD shifts only prime the chain; every later shift completes a window.
  assign w_win_shift = shift_en_o && (r_sh_cnt >= SH_LEAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt    <= '0;
      r_sh_cnt    <= '0;
      r_fl_cnt    <= '0;
      r_nrow      <= '0;
      r_ncol      <= '0;
      row_o       <= '0;
      col_o       <= '0;
      win_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      busy_o      <= (w_state_next != S_IDLE);
      done_o      <= (r_state == S_DONE);
      err_o       <= err_o | (start_i && (r_state != S_IDLE));
      win_valid_o <= w_win_shift;

      if (r_state == S_IDLE && start_i) begin
        r_in_cnt <= '0;
        r_sh_cnt <= '0;
        r_nrow   <= '0;
        r_ncol   <= '0;
        row_o    <= '0;
        col_o    <= '0;
      end

      if (ready_o && valid_i) r_in_cnt <= r_in_cnt + IW'(1);
      if (shift_en_o)         r_sh_cnt <= r_sh_cnt + SW'(1);

      if (w_last_px)                 r_fl_cnt <= '0;
      else if (r_state == S_FLUSH)   r_fl_cnt <= r_fl_cnt + FW'(1);

      // r_nrow/r_ncol hold the centre of the next window to be completed.
      if (w_win_shift) begin
        row_o <= r_nrow;
        col_o <= r_ncol;
        if (r_ncol == COL_LAST) begin
          r_ncol <= '0;
          r_nrow <= r_nrow + RW'(1);
        end else begin
          r_ncol <= r_ncol + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: an 8x6 and a 5x5 instance checked every cycle
// against a raster-index model, plus literal frame-level expectations.
module tb_line_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_s, start_s, valid_s;
  logic [1:0] ready_w, shift_w, flush_w, win_w, busy_w, done_w, err_w;
  logic [9:0] row_w [2];
  logic [9:0] col_w [2];

  line_window_ctrl #(.IMG_W(8), .IMG_H(6), .CW(10), .RW(10)) dut_a (
    .clk(clk), .rst(rst_s[0]), .start_i(start_s[0]), .valid_i(valid_s[0]),
    .ready_o(ready_w[0]), .shift_en_o(shift_w[0]), .flush_o(flush_w[0]),
    .win_valid_o(win_w[0]), .row_o(row_w[0]), .col_o(col_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0]));

  line_window_ctrl #(.IMG_W(5), .IMG_H(5), .CW(10), .RW(10)) dut_b (
    .clk(clk), .rst(rst_s[1]), .start_i(start_s[1]), .valid_i(valid_s[1]),
    .ready_o(ready_w[1]), .shift_en_o(shift_w[1]), .flush_o(flush_w[1]),
    .win_valid_o(win_w[1]), .row_o(row_w[1]), .col_o(col_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: phase 0 idle, 1 stream, 2 flush, 3 done
  int mw [2] = '{8, 5};
  int mh [2] = '{6, 5};
  int m_phase [2], m_acc [2], m_k [2], m_fl [2], m_row [2], m_col [2];
  bit m_err [2], m_win [2], m_busy [2], m_done [2];

  int n_win [2], n_done [2], n_flush [2], n_shift [2];
  int first_win_cyc [2], lead_shift_cyc [2], last_win_cyc [2], done_cyc [2];
  int last_row [2], last_col [2];

  task automatic chk(input string name, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0d expected=%0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_update(input int d);
    int lead;
    bit sh;
    lead = 2 * mw[d] + 2;
    if (rst_s[d]) begin
      m_phase[d] = 0; m_acc[d] = 0; m_k[d] = 0; m_fl[d] = 0;
      m_row[d] = 0; m_col[d] = 0;
      m_err[d] = 0; m_win[d] = 0; m_busy[d] = 0; m_done[d] = 0;
    end else begin
      sh = (m_phase[d] == 1 && valid_s[d]) || (m_phase[d] == 2);
      m_done[d] = (m_phase[d] == 3);
      m_win[d] = 0;
      if (sh && m_k[d] >= lead) begin
        m_win[d] = 1;
        m_row[d] = (m_k[d] - lead) / mw[d];
        m_col[d] = (m_k[d] - lead) % mw[d];
      end
      if (sh) m_k[d]++;
      if (start_s[d] && m_phase[d] != 0) m_err[d] = 1;
      case (m_phase[d])
        0: if (start_s[d]) begin
             m_phase[d] = 1; m_acc[d] = 0; m_k[d] = 0; m_row[d] = 0; m_col[d] = 0;
           end
        1: if (valid_s[d]) begin
             m_acc[d]++;
             if (m_acc[d] == mw[d] * mh[d]) begin m_phase[d] = 2; m_fl[d] = 0; end
           end
        2: if (m_fl[d] == lead - 1) m_phase[d] = 3; else m_fl[d]++;
        default: m_phase[d] = 0;
      endcase
      m_busy[d] = (m_phase[d] != 0);
    end
  endtask

  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, ready_w[d], int'(m_phase[d] == 1));
      chk("shift_en", d, shift_w[d], int'((m_phase[d] == 1 && valid_s[d]) || m_phase[d] == 2));
      chk("flush", d, flush_w[d], int'(m_phase[d] == 2));
      if (shift_w[d]) begin
        if (n_shift[d] == 2 * mw[d] + 2) lead_shift_cyc[d] = cyc;
        n_shift[d]++;
      end
      if (flush_w[d]) n_flush[d]++;
      model_update(d);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      chk("win_valid", d, win_w[d], int'(m_win[d]));
      chk("row", d, int'(row_w[d]), m_row[d]);
      chk("col", d, int'(col_w[d]), m_col[d]);
      chk("busy", d, busy_w[d], int'(m_busy[d]));
      chk("done", d, done_w[d], int'(m_done[d]));
      chk("err", d, err_w[d], int'(m_err[d]));
      if (win_w[d]) begin
        n_win[d]++;
        if (n_win[d] == 1) first_win_cyc[d] = cyc;
        last_win_cyc[d] = cyc;
        last_row[d] = int'(row_w[d]);
        last_col[d] = int'(col_w[d]);
      end
      if (done_w[d]) begin
        n_done[d]++;
        done_cyc[d] = cyc;
      end
    end
  endtask

  task automatic frame(input int d, input int gap, input int err_px, input int abort_px,
                       input bit start_in_done);
    bit finished;
    finished = 0;
    n_win[d] = 0; n_done[d] = 0; n_flush[d] = 0; n_shift[d] = 0;
    first_win_cyc[d] = -1; lead_shift_cyc[d] = -1; last_win_cyc[d] = -1; done_cyc[d] = -1;
    last_row[d] = -1; last_col[d] = -1;
    start_s[d] = 1'b1;
    step();
    start_s[d] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      valid_s[d] = (gap == 0) || (i % gap != gap - 1);
      start_s[d] = (m_phase[d] == 1 && m_acc[d] == err_px) || (start_in_done && m_phase[d] == 3);
      if (abort_px > 0 && m_phase[d] == 1 && m_acc[d] == abort_px) begin
        valid_s[d] = 1'b0;
        start_s[d] = 1'b0;
        rst_s[d] = 1'b1;
        step();
        rst_s[d] = 1'b0;
        finished = 1;
        break;
      end
      step();
      if (m_phase[d] == 0) begin
        start_s[d] = 1'b0;
        valid_s[d] = 1'b0;
        step();
        step();
        finished = 1;
        break;
      end
    end
    start_s[d] = 1'b0;
    valid_s[d] = 1'b0;
    if (!finished) chk("frame_timeout", d, 0, 1);
  endtask

  initial begin
    rst_s = 2'b11; start_s = 2'b00; valid_s = 2'b00;
    for (int d = 0; d < 2; d++) model_update(d);
    step(); step(); step();
    rst_s = 2'b00;
    step();
    chk("rst_busy", 0, busy_w[0], 0);
    chk("rst_win", 0, win_w[0], 0);
    chk("rst_err", 1, err_w[1], 0);
    $display("reset: busy=%0d/%0d err=%0d/%0d", busy_w[0], busy_w[1], err_w[0], err_w[1]);

    frame(0, 0, -1, 0, 0);
    $display("frame 8x6 contiguous: windows=%0d flush=%0d done=%0d last=(%0d,%0d)",
             n_win[0], n_flush[0], n_done[0], last_row[0], last_col[0]);
    chk("t1_windows", 0, n_win[0], 48);
    chk("t1_flush_cycles", 0, n_flush[0], 18);
    chk("t1_done_pulses", 0, n_done[0], 1);
    chk("t1_first_win_latency", 0, first_win_cyc[0] - lead_shift_cyc[0], 1);
    chk("t1_last_row", 0, last_row[0], 5);
    chk("t1_last_col", 0, last_col[0], 7);
    chk("t1_busy_after", 0, busy_w[0], 0);

    frame(0, 3, -1, 0, 0);
    $display("frame 8x6 stalls: windows=%0d flush=%0d done=%0d last=(%0d,%0d)",
             n_win[0], n_flush[0], n_done[0], last_row[0], last_col[0]);
    chk("t2_windows", 0, n_win[0], 48);
    chk("t2_flush_cycles", 0, n_flush[0], 18);
    chk("t2_last_row", 0, last_row[0], 5);
    chk("t2_last_col", 0, last_col[0], 7);

    frame(0, 0, 10, 0, 0);
    step();
    $display("frame 8x6 start-in-stream: windows=%0d err=%0d", n_win[0], err_w[0]);
    chk("t3_err_sticky", 0, err_w[0], 1);
    chk("t3_windows", 0, n_win[0], 48);
    chk("t3_done_pulses", 0, n_done[0], 1);

    frame(0, 0, -1, 20, 0);
    $display("frame 8x6 aborted at 20: busy=%0d err=%0d win=%0d done=%0d",
             busy_w[0], err_w[0], win_w[0], n_done[0]);
    chk("t4_abort_busy", 0, busy_w[0], 0);
    chk("t4_abort_err", 0, err_w[0], 0);
    chk("t4_abort_no_done", 0, n_done[0], 0);
    frame(0, 0, -1, 0, 0);
    $display("frame 8x6 after abort: windows=%0d done=%0d", n_win[0], n_done[0]);
    chk("t4_windows", 0, n_win[0], 48);
    chk("t4_done_pulses", 0, n_done[0], 1);

    frame(1, 0, -1, 0, 1);
    $display("frame 5x5: windows=%0d flush=%0d done=%0d last=(%0d,%0d) err=%0d",
             n_win[1], n_flush[1], n_done[1], last_row[1], last_col[1], err_w[1]);
    chk("t5_windows", 1, n_win[1], 25);
    chk("t5_flush_cycles", 1, n_flush[1], 12);
    chk("t5_last_row", 1, last_row[1], 4);
    chk("t5_last_col", 1, last_col[1], 4);
    chk("t5_done_after_last", 1, done_cyc[1] - last_win_cyc[1], 1);
    chk("t5_err_start_in_done", 1, err_w[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
